// File: rtl/span_param_master.sv
// Bus initiator: buffers NUM_REGS SPAN parameters, writes them to the span_cme slave, settles, then reads one result.
// Defining SPAN_WR_READBACK_EN adds a read-back compare after every parameter write (sticky verify_err).
module span_param_master #(
    parameter int NUM_REGS      = 29,
    parameter int SETTLE_CYCLES = 64,
    parameter int RESULT_OFFSET = 0,
    parameter int READ_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    input  logic        ld_clear,
    output logic [4:0]  count,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        chipselect,
    output logic        write,
    output logic        read,
    output logic [4:0]  offset,
    output logic [15:0] writeData,
    input  logic [15:0] readData,
    output logic        verify_err
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMR_W = $clog2(SETTLE_CYCLES + READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SETTLE, S_RDREQ, S_RDWAIT, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               buf_we;
    logic               can_load;
    logic               last_idx;
    logic [15:0]        buf_q [NUM_REGS];

`ifdef SPAN_WR_READBACK_EN
    typedef enum logic [1:0] {P_WR, P_RB, P_WAIT} phase_e;
    phase_e phase_q, phase_d;
    logic   verify_err_q, verify_err_d;
`endif

    assign can_load = (state_q == S_IDLE) && (count_q < CNT_W'(NUM_REGS));
    assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_d        = state_q;
        idx_d          = idx_q;
        tmr_d          = tmr_q;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        buf_we         = 1'b0;
        chipselect     = 1'b0;
        write          = 1'b0;
        read           = 1'b0;
        offset         = '0;
        writeData      = '0;
        done           = 1'b0;
        busy           = 1'b0;
`ifdef SPAN_WR_READBACK_EN
        phase_d        = phase_q;
        verify_err_d   = verify_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Accepted start outranks ld_clear, which outranks a load.
                if (start && (count_q == CNT_W'(NUM_REGS))) begin
                    state_d        = S_WRITE;
                    idx_d          = '0;
                    tmr_d          = '0;
                    result_valid_d = 1'b0;
`ifdef SPAN_WR_READBACK_EN
                    phase_d        = P_WR;
                    verify_err_d   = 1'b0;
`endif
                end else if (ld_clear) begin
                    count_d = '0;
                end else if (ld_valid && can_load) begin
                    buf_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end

            S_WRITE: begin
                busy = 1'b1;
`ifdef SPAN_WR_READBACK_EN
                unique case (phase_q)
                    P_WR: begin
                        chipselect = 1'b1;
                        write      = 1'b1;
                        offset     = 5'(idx_q);
                        writeData  = buf_q[idx_q];
                        phase_d    = P_RB;
                    end
                    P_RB: begin
                        chipselect = 1'b1;
                        read       = 1'b1;
                        offset     = 5'(idx_q);
                        phase_d    = P_WAIT;
                        tmr_d      = '0;
                    end
                    default: begin
                        if (tmr_q == TMR_W'(READ_LATENCY - 1)) begin
                            if (readData != buf_q[idx_q]) verify_err_d = 1'b1;
                            phase_d = P_WR;
                            tmr_d   = '0;
                            if (last_idx) state_d = S_SETTLE;
                            else          idx_d   = idx_q + 1'b1;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                endcase
`else
                chipselect = 1'b1;
                write      = 1'b1;
                offset     = 5'(idx_q);
                writeData  = buf_q[idx_q];
                if (last_idx) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`endif
            end

            S_SETTLE: begin
                busy = 1'b1;
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_RDREQ;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            S_RDREQ: begin
                busy       = 1'b1;
                chipselect = 1'b1;
                read       = 1'b1;
                offset     = 5'(RESULT_OFFSET);
                state_d    = S_RDWAIT;
                tmr_d      = '0;
            end

            S_RDWAIT: begin
                busy = 1'b1;
                if (tmr_q == TMR_W'(READ_LATENCY - 1)) begin
                    result_d       = readData;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (!reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            tmr_q          <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
`ifdef SPAN_WR_READBACK_EN
            phase_q        <= P_WR;
            verify_err_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tmr_q          <= tmr_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
`ifdef SPAN_WR_READBACK_EN
            phase_q        <= phase_d;
            verify_err_q   <= verify_err_d;
`endif
        end
    end

    // NOTE: the parameter buffer is deliberately not reset; count gates every read, so its contents never matter after reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[IDX_W'(count_q)] <= ld_data;
    end

    assign ld_ready     = can_load;
    assign count        = 5'(count_q);
    assign result       = result_q;
    assign result_valid = result_valid_q;
`ifdef SPAN_WR_READBACK_EN
    assign verify_err   = verify_err_q;
`else
    assign verify_err   = 1'b0;
`endif

endmodule

// File: doc/span_param_master.md
Name: span_param_master

Overview:
- Bus initiator that drives the span_cme register slave port.
- Buffers NUM_REGS 16-bit SPAN parameters loaded by the host side: price scan, risk-array entries, spreads and charges.
- On start, writes them to offsets 0..NUM_REGS-1, one write per cycle, then waits a settle interval.
- Reads the result register once and presents it as result, with a done pulse.

Parameters:
NUM_REGS, 29, number of parameter words written per run (offsets 0..NUM_REGS-1)
SETTLE_CYCLES, 64, idle cycles between the last write and the result read
RESULT_OFFSET, 0, offset driven during the result read
READ_LATENCY, 1, cycles from the read cycle until readData is valid

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
ld_valid  input  1  parameter word valid
ld_data  input  16  parameter word (two's complement where signed)
ld_ready  output  1  buffer can accept a word
ld_clear  input  1  empty the buffer (count<=0)
count  output  5  number of words loaded
start  input  1  begin a run
busy  output  1  run in progress
done  output  1  one-cycle pulse when result is updated
result  output  16  captured readData
result_valid  output  1  result holds data from the last completed run
chipselect  output  1  slave select
write  output  1  write strobe
read  output  1  read strobe
offset  output  5  register offset
writeData  output  16  write data
readData  input  16  slave read data
verify_err  output  1  sticky readback mismatch (tied 0 without the optional feature)

Behaviour:
- Reset: reset sampled low at a clk edge forces all state to reset values at that edge, including mid-run. No bus cycle completes after that edge.
- Reset values:
  - Outputs: chipselect, write, read, done, busy, result_valid, verify_err = 0; offset = 0; writeData = 0; result = 0; count = 0; ld_ready = 1.
  - State: FSM = IDLE; buffer contents are don't-care.
- States: IDLE, WRITE, SETTLE, RDREQ, RDWAIT, DONE.
- IDLE load path:
  - ld_valid & ld_ready stores ld_data at buffer[count]; count increments.
  - ld_ready = (state==IDLE) & (count<NUM_REGS).
  - ld_clear has priority over ld_valid in the same cycle.
- Start acceptance:
  - start is accepted only in IDLE with count==NUM_REGS. Otherwise it is ignored: no bus activity, no error.
  - start has priority over ld_clear in the same cycle.
  - On acceptance: verify_err <= 0, result_valid <= 0, busy <= 1.
- WRITE:
  - Begins the cycle after start is accepted.
  - For NUM_REGS consecutive cycles, i = 0..NUM_REGS-1: chipselect=1, write=1, read=0, offset=i, writeData=buffer[i].
  - No gaps. The slave has no wait-request.
- SETTLE: SETTLE_CYCLES cycles with all strobes 0, offset=0, writeData=0.
- RDREQ: one cycle with chipselect=1, read=1, write=0, offset=RESULT_OFFSET.
- RDWAIT:
  - Lasts READ_LATENCY cycles, strobes 0.
  - readData is sampled at the edge ending the last RDWAIT cycle and loaded into result.
- DONE: one cycle with done=1, result_valid=1, busy=0; then IDLE.
- Timing: defaults with start at edge E0:
  - writes occupy cycles 1..29;
  - settle occupies 30..93;
  - read occurs at cycle 94;
  - done=1 and result are valid in cycle 96.
- After a run:
  - Buffer and count are retained, so a new start reruns without reloading.
  - result/result_valid hold until the next accepted start.
- start while busy is ignored. ld_valid while busy is not accepted (ld_ready=0).
- count is never incremented past NUM_REGS.
- The offset counter width is 5; NUM_REGS must be ≤32.

Optional Feature:
- Macro: SPAN_WR_READBACK_EN.
- Defined:
  - Each WRITE slot becomes write cycle (offset i), then read cycle (chipselect=1, read=1, offset i), then READ_LATENCY wait cycles.
  - readData is compared with buffer[i]; a mismatch sets verify_err=1, which is sticky until the next accepted start.
  - The run continues on mismatch.
  - WRITE phase length is NUM_REGS*(2+READ_LATENCY) cycles; with defaults, done appears in cycle 154.
- Undefined: behaviour exactly as above; verify_err is constant 0.

Test Plan:
1. Full run, default parameters. Load 300,30,30,0xFFF6,0xFFF6,0xFFEC,5,0,0,3,1,5,1,3,5,0,0,2,4,6,50,60,70,80,90,100,100,110,120. Pulse start; bench slave returns 0x1234 on read. Check:
   - write cycles show offset 0 data 300, offset 3 data 0xFFF6, offset 5 data 0xFFEC, offset 28 data 120;
   - 29 contiguous writes, then 64 idle cycles;
   - read at offset 0 in cycle 94;
   - done in cycle 96 with result=0x1234 and result_valid=1.
2. Incomplete buffer: load 28 words, pulse start. Check no strobes for 10 cycles and busy=0; then load word 29, ld_ready->0, start runs.
3. Reset mid-run: drop reset low during the write at offset 10. Check that at the next edge all strobes=0, count=0, busy=0, and no further bus cycles.
4. Rerun and clear: after a completed run, pulse start again without loading. Check identical write sequence and result_valid=0 until the new done. Then ld_clear→count=0 and start is ignored.
5. Simultaneous inputs: start & ld_clear with count=29 → run starts. ld_valid & ld_clear → count=0.
6. SPAN_WR_READBACK_EN: slave returns 0x0001 instead of 0x0000 on readback of offset 7. Check verify_err=1 from that compare onward, remaining offsets still written, done in cycle 154.
